// File: rtl/i2c_slave_read_byte.sv
// Receives one I2C byte (MSB first) by sampling SDA on SCL rising edges seen in the system clock domain.
// Define I2C_SLAVE_READ_BYTE_BUS_CONDITION_DETECT_EN to abort on START/STOP seen mid-byte (error strobe).
module i2c_slave_read_byte (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   input  logic scl,
   input  logic sda,
   output logic data,
   output logic save,
   output logic finish,
   output logic error
);

   typedef enum logic [1:0] {IDLE, RECEIVE, WAIT_LOW} state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       data_q, data_d;
   logic       save_q, save_d;
   logic       finish_q, finish_d;
   logic       scl_last_q;
   logic       scl_rise, scl_fall;
   logic       bus_cond;

   assign scl_rise = !scl_last_q && scl;
   assign scl_fall = scl_last_q && !scl;

`ifdef I2C_SLAVE_READ_BYTE_BUS_CONDITION_DETECT_EN
   logic sda_last_q;
   logic error_q, error_d;

   // SDA moving while SCL stays high is a START or STOP from the master
   assign bus_cond = (state_q != IDLE) && scl_last_q && scl && (sda_last_q != sda);
   assign error_d  = enable && bus_cond;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sda_last_q <= 1'b1;
         error_q    <= 1'b0;
      end else begin
         sda_last_q <= sda;
         error_q    <= error_d;
      end
   end

   assign error = error_q;
`else
   assign bus_cond = 1'b0;
   assign error    = 1'b0;
`endif

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         data_q     <= 1'b0;
         save_q     <= 1'b0;
         finish_q   <= 1'b0;
         scl_last_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         save_q     <= save_d;
         finish_q   <= finish_d;
         scl_last_q <= scl;
      end
   end

   // next state; enable low outranks any bus event or SCL edge
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = RECEIVE;
               cnt_d   = 3'd0;
            end
         end
         RECEIVE: begin
            if (!enable || bus_cond) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else if (scl_rise) begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            if (!enable || bus_cond) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else if (scl_fall) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // registered outputs: strobes one clock after the qualifying edge
   always_comb begin
      data_d   = data_q;
      save_d   = 1'b0;
      finish_d = 1'b0;
      if (enable && !bus_cond) begin
         if (state_q == RECEIVE && scl_rise) begin
            data_d = sda;
            save_d = 1'b1;
         end
         if (state_q == WAIT_LOW && scl_fall) finish_d = 1'b1;
      end
   end

   assign data   = data_q;
   assign save   = save_q;
   assign finish = finish_q;

endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// Randomized bench for i2c_slave_read_byte: a bit-banged master drives SCL/SDA, a byte-level model predicts saves/finishes.
module tb_i2c_slave_read_byte;

   logic clock = 1'b0;
   logic reset_n, enable, scl, sda;
   logic data, save, finish, error;

   int n_tests = 0;
   int n_fail  = 0;

   logic bits[$];
   logic exp_bits[$];
   int   fin_cnt, err_cnt, ovl_cnt;
   int   exp_fin, exp_err;

   always #10 clock = ~clock;

   i2c_slave_read_byte dut (
      .clock  (clock),
      .reset_n(reset_n),
      .enable (enable),
      .scl    (scl),
      .sda    (sda),
      .data   (data),
      .save   (save),
      .finish (finish),
      .error  (error)
   );

   always @(negedge clock) begin
      if (reset_n) begin
         if (save) bits.push_back(data);
         if (finish) fin_cnt++;
         if (error) err_cnt++;
         if (save && finish) ovl_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic mon_clear();
      bits.delete();
      exp_bits.delete();
      fin_cnt = 0;
      err_cnt = 0;
      exp_fin = 0;
      exp_err = 0;
   endtask

   // reference model: a completed byte contributes 8 MSB-first bits and one finish
   task automatic model_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) exp_bits.push_back(b[i]);
      if (n == 8) exp_fin++;
   endtask

   // called at a negedge with scl low; ends right after scl falls
   task automatic send_bit(input logic b);
      sda = b;
      clk(4);
      scl = 1'b1;
      clk(4);
      scl = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] b, input int first, input int n);
      for (int i = 7 - first; i > 7 - first - n; i--) send_bit(b[i]);
   endtask

   task automatic compare(input string tag);
      chk({tag, "_nsave"}, bits.size(), exp_bits.size());
      for (int i = 0; i < exp_bits.size() && i < bits.size(); i++)
         chk({tag, "_bit"}, {31'd0, bits[i]}, {31'd0, exp_bits[i]});
      chk({tag, "_finish"}, fin_cnt, exp_fin);
      chk({tag, "_error"}, err_cnt, exp_err);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b2b[4];
      logic [7:0] rb;
      int         k;
      b2b = '{8'h13, 8'h57, 8'h9B, 8'hDF};
      reset_n = 1'b0; enable = 1'b0; scl = 1'b1; sda = 1'b1;
      mon_clear();
      ovl_cnt = 0;
      #5;
      chk("rst_data", {31'd0, data}, 0);
      chk("rst_save", {31'd0, save}, 0);
      chk("rst_finish", {31'd0, finish}, 0);
      chk("rst_error", {31'd0, error}, 0);
      clk(2);
      reset_n = 1'b1;
      clk(3);

      // single byte, enable after an SCL fall
      scl = 1'b0;
      clk(1);
      enable = 1'b1;
      send_bits(8'hA5, 0, 8); model_bits(8'hA5, 8);
      clk(4);
      compare("single");
      chk("data_hold", {31'd0, data}, 1);

      // back-to-back with enable held
      mon_clear();
      foreach (b2b[i]) begin
         send_bits(b2b[i], 0, 8);
         model_bits(b2b[i], 8);
      end
      clk(4);
      compare("b2b");

      // abort after 3 bits, then a clean 0xFF
      mon_clear();
      send_bits(8'h5A, 0, 3); model_bits(8'h5A, 3);
      enable = 1'b0;
      send_bits(8'h5A, 3, 5);
      clk(4);
      enable = 1'b1;
      send_bits(8'hFF, 0, 8); model_bits(8'hFF, 8);
      clk(4);
      compare("abort");

      // reset mid-byte
      mon_clear();
      send_bits(8'h3C, 0, 5);
      #3 reset_n = 1'b0;
      #1;
      chk("mid_rst_data", {31'd0, data}, 0);
      chk("mid_rst_save", {31'd0, save}, 0);
      chk("mid_rst_finish", {31'd0, finish}, 0);
      enable = 1'b0;
      clk(2);
      reset_n = 1'b1;
      clk(2);
      mon_clear();
      enable = 1'b1;
      send_bits(8'hC3, 0, 8); model_bits(8'hC3, 8);
      clk(4);
      compare("post_rst");

      // STOP during the 5th bit of 0x96 (that bit is 0)
      mon_clear();
      send_bits(8'h96, 0, 4);
      sda = 1'b0;
      clk(4);
      scl = 1'b1;
      clk(2);
      sda = 1'b1;
      clk(2);
`ifdef I2C_SLAVE_READ_BYTE_BUS_CONDITION_DETECT_EN
      enable = 1'b0;
      scl = 1'b0;
      model_bits(8'h96, 5);
      exp_err = 1;
      send_bits(8'h96, 5, 3);
      clk(4);
      enable = 1'b1;
`else
      scl = 1'b0;
      send_bits(8'h96, 5, 3);
      model_bits(8'h96, 8);
      clk(4);
`endif
      compare("stop");

      // randomized mix of full bytes, enable gaps and aborts
      mon_clear();
      for (int r = 0; r < 10; r++) begin
         rb = 8'($urandom);
         case ($urandom_range(0, 2))
            0: begin
               send_bits(rb, 0, 8); model_bits(rb, 8);
            end
            1: begin
               send_bits(rb, 0, 8); model_bits(rb, 8);
               clk(2);
               enable = 1'b0;
               clk($urandom_range(1, 3));
               enable = 1'b1;
            end
            default: begin
               k = $urandom_range(1, 7);
               send_bits(rb, 0, k); model_bits(rb, k);
               enable = 1'b0;
               send_bits(rb, k, 8 - k);
               enable = 1'b1;
            end
         endcase
      end
      clk(4);
      compare("rand");
      chk("save_finish_overlap", ovl_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
